// File: rtl/cy_stream_rr_arbiter.sv
// cy_stream_rr_arbiter: round-robin arbiter that merges N valid/ready
// upstream streams onto one downstream channel, granting whole bursts.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_valid/i_data/i_last  per-requester stream (requester k at k*DW)
//   o_ready             per-requester ready (registered-state only)
//   o_valid/o_data/o_last/o_src  merged downstream beat and its source
//   i_ready             downstream ready
//
// Beats pass through a main + skid register pair so that o_ready never
// depends combinationally on i_ready or i_valid.

module cy_stream_rr_arbiter #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int MAX_BEATS = 0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [N-1:0]           i_valid,
    input  logic [N*DW-1:0]        i_data,
    input  logic [N-1:0]           i_last,
    output logic [N-1:0]           o_ready,
    output logic                   o_valid,
    output logic [DW-1:0]          o_data,
    output logic                   o_last,
    output logic [$clog2(N)-1:0]   o_src,
    input  logic                   i_ready
);

    localparam int SW = $clog2(N);
    localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            main_vld_q, main_vld_d;
    logic [DW-1:0]   main_data_q, main_data_d;
    logic            main_last_q, main_last_d;
    logic [SW-1:0]   main_src_q, main_src_d;

    logic            skid_vld_q, skid_vld_d;
    logic [DW-1:0]   skid_data_q, skid_data_d;
    logic            skid_last_q, skid_last_d;
    logic [SW-1:0]   skid_src_q, skid_src_d;

    logic            g_valid;
    logic [DW-1:0]   g_data;
    logic            g_last;
    logic            acc;
    logic            dn;
    logic            rel;
    logic [SW-1:0]   pick;
    logic            pick_ok;

    assign g_valid = i_valid[grant_q];
    assign g_data  = i_data[grant_q*DW +: DW];
    assign g_last  = i_last[grant_q];

    // Ready only while locked and the skid slot is free.
    always_comb begin
        o_ready = '0;
        if (state_q == LOCK && !skid_vld_q) begin
            o_ready[grant_q] = 1'b1;
        end
    end

    assign acc = (state_q == LOCK) && !skid_vld_q && g_valid;
    assign dn  = main_vld_q && i_ready;
    assign rel = acc &&
                 (g_last || (MAX_BEATS > 0 && cnt_q == CNT_LAST));

    // Scan downward in offset so the smallest offset from rr_ptr wins.
    always_comb begin
        logic [SW:0] idx;
        pick    = rr_ptr_q;
        pick_ok = 1'b0;
        idx     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr_q} + (SW+1)'(i);
            if (idx >= (SW+1)'(N)) begin
                idx = idx - (SW+1)'(N);
            end
            if (i_valid[idx[SW-1:0]]) begin
                pick    = idx[SW-1:0];
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_ok) begin
                    grant_d = pick;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (acc) begin
                    cnt_d = cnt_q + 1'b1;
                    if (rel) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_q == SW'(N - 1)) ?
                                   '0 : grant_q + 1'b1;
                        cnt_d    = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Skid is only ever filled while main is stalled, and upstream is
    // blocked while skid is full, so acc and skid_vld_q never coexist.
    always_comb begin
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        main_last_d = main_last_q;
        main_src_d  = main_src_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        skid_src_d  = skid_src_q;
        if (dn) begin
            if (skid_vld_q) begin
                main_data_d = skid_data_q;
                main_last_d = skid_last_q;
                main_src_d  = skid_src_q;
                skid_vld_d  = 1'b0;
            end else if (acc) begin
                main_data_d = g_data;
                main_last_d = g_last;
                main_src_d  = grant_q;
            end else begin
                main_vld_d  = 1'b0;
            end
        end else if (acc) begin
            if (!main_vld_q) begin
                main_vld_d  = 1'b1;
                main_data_d = g_data;
                main_last_d = g_last;
                main_src_d  = grant_q;
            end else begin
                skid_vld_d  = 1'b1;
                skid_data_d = g_data;
                skid_last_d = g_last;
                skid_src_d  = grant_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            main_vld_q  <= 1'b0;
            main_data_q <= '0;
            main_last_q <= 1'b0;
            main_src_q  <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            skid_src_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            main_vld_q  <= main_vld_d;
            main_data_q <= main_data_d;
            main_last_q <= main_last_d;
            main_src_q  <= main_src_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            skid_src_q  <= skid_src_d;
        end
    end

    assign o_valid = main_vld_q;
    assign o_data  = main_data_q;
    assign o_last  = main_last_q;
    assign o_src   = main_src_q;

endmodule

// File: tb/tb_cy_stream_rr_arbiter.sv
// tb_cy_stream_rr_arbiter: randomized + directed bench for the
// round-robin stream arbiter with a queue-based reference model.

module tb_cy_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            i_reset;
    logic [N-1:0]    i_valid;
    logic [N*DW-1:0] i_data;
    logic [N-1:0]    i_last;
    logic [N-1:0]    o_ready;
    logic            o_valid;
    logic [DW-1:0]   o_data;
    logic            o_last;
    logic [SW-1:0]   o_src;
    logic            i_ready;

    always #5 clk = ~clk;

    cy_stream_rr_arbiter #(.N(N), .DW(DW), .MAX_BEATS(MB)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_src   (o_src),
        .i_ready (i_ready)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            s;
    } beat_t;

    beat_t pend[N][$];
    beat_t exp_q[$];
    beat_t m_buf[$];

    int          total = 0;
    int          bad   = 0;
    int          seq   = 0;
    logic [N-1:0] held = '0;
    bit          m_lock = 0;
    int          m_ptr  = 0;
    int          m_grant = 0;
    int          m_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add_burst(input int k, input int len, input int base,
                             input bit has_last);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.d = DW'(base + j);
            b.l = has_last && (j == len - 1);
            b.s = k;
            pend[k].push_back(b);
        end
    endtask

    function automatic int pend_total();
        int t = 0;
        for (int k = 0; k < N; k++) t += pend[k].size();
        return t;
    endfunction

    // One clock: check outputs against the model, drive inputs, then
    // advance the model to what the DUT should hold after the next edge.
    task automatic step(input logic [N-1:0] en, input logic rdy,
                        input logic rst);
        logic [N-1:0] exp_rdy;
        bit           acc;
        bit           dn;
        bit           found;
        beat_t        b;
        int           g;
        @(negedge clk);
        exp_rdy = '0;
        if (m_lock && m_buf.size() < 2) exp_rdy[m_grant] = 1'b1;
        check("o_ready", 32'(o_ready), 32'(exp_rdy));
        check("o_valid", 32'(o_valid), 32'(m_buf.size() > 0));
        i_reset = rst;
        i_ready = rdy;
        for (int k = 0; k < N; k++) begin
            i_valid[k] = (en[k] || held[k]) && pend[k].size() > 0;
            if (pend[k].size() > 0) begin
                i_data[k*DW +: DW] = pend[k][0].d;
                i_last[k]          = pend[k][0].l;
            end else begin
                i_data[k*DW +: DW] = DW'($urandom);
                i_last[k]          = 1'($urandom);
            end
        end
        if (rst) begin
            m_lock  = 0;
            m_ptr   = 0;
            m_grant = 0;
            m_cnt   = 0;
            held    = '0;
            m_buf.delete();
            exp_q.delete();
            for (int k = 0; k < N; k++) pend[k].delete();
        end else begin
            acc  = m_lock && m_buf.size() < 2 && i_valid[m_grant];
            dn   = m_buf.size() > 0 && rdy;
            held = i_valid;
            b    = '{d: '0, l: 1'b0, s: 0};
            if (!m_lock) begin
                found = 0;
                for (int j = 0; j < N; j++) begin
                    g = (m_ptr + j) % N;
                    if (!found && i_valid[g]) begin
                        m_grant = g;
                        m_lock  = 1;
                        found   = 1;
                    end
                end
            end else if (acc) begin
                b   = pend[m_grant].pop_front();
                b.s = m_grant;
                held[m_grant] = 1'b0;
                exp_q.push_back(b);
                m_cnt++;
                if (b.l || (MB > 0 && m_cnt == MB)) begin
                    m_lock = 0;
                    m_ptr  = (m_grant + 1) % N;
                    m_cnt  = 0;
                end
            end
            if (dn) void'(m_buf.pop_front());
            if (acc) m_buf.push_back(b);
        end
    endtask

    // Scoreboard monitor: every downstream transfer pops one expectation.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #1;
            if (i_reset === 1'b0 && o_valid === 1'b1 && i_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat act=%0h exp=none t=%0t",
                             o_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("o_data", 32'(o_data), 32'(e.d));
                    check("o_last", 32'(o_last), 32'(e.l));
                    check("o_src", 32'(o_src), 32'(e.s));
                end
            end
        end
    end

    initial begin
        i_reset = 1'b1;
        i_valid = '0;
        i_data  = '0;
        i_last  = '0;
        i_ready = 1'b0;

        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        check("rst_o_data", 32'(o_data), 32'h0);
        check("rst_o_last", 32'(o_last), 32'h0);
        check("rst_o_src", 32'(o_src), 32'h0);
        check("rst_o_ready", 32'(o_ready), 32'h0);

        // single burst from requester 2
        pend[2].push_back('{d: 8'hA1, l: 1'b0, s: 2});
        pend[2].push_back('{d: 8'hA2, l: 1'b0, s: 2});
        pend[2].push_back('{d: 8'hA3, l: 1'b1, s: 2});
        repeat (8) step(4'b0100, 1'b1, 1'b0);

        // fairness with one-beat bursts
        for (int k = 0; k < N; k++) begin
            for (int r = 0; r < 4; r++) add_burst(k, 1, 16 * k + r, 1);
        end
        repeat (40) step(4'b1111, 1'b1, 1'b0);

        // backpressure on a 5-beat burst
        add_burst(1, 5, 8'h50, 1);
        repeat (6) step(4'b0010, 1'b0, 1'b0);
        check("bp_stall_ready", 32'(o_ready), 32'h0);
        repeat (12) step(4'b0010, 1'b1, 1'b0);

        // watchdog: long burst without last competing with requester 3
        add_burst(0, 12, 8'h60, 0);
        add_burst(3, 2, 8'h70, 1);
        repeat (35) step(4'b1001, 1'b1, 1'b0);

        // lock hold while the owner pauses
        add_burst(1, 4, 8'h80, 1);
        add_burst(2, 1, 8'h90, 1);
        repeat (3) step(4'b0110, 1'b1, 1'b0);
        repeat (3) step(4'b0100, 1'b1, 1'b0);
        repeat (8) step(4'b0110, 1'b1, 1'b0);

        // reset with main and skid full
        add_burst(0, 4, 8'hC0, 1);
        repeat (5) step(4'b0001, 1'b0, 1'b0);
        step('0, 1'b0, 1'b1);
        add_burst(3, 1, 8'hD0, 1);
        step(4'b1000, 1'b1, 1'b0);
        check("mrst_o_valid", 32'(o_valid), 32'h0);
        check("mrst_o_ready", 32'(o_ready), 32'h0);
        repeat (5) step(4'b1000, 1'b1, 1'b0);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if (pend[k].size() == 0 && $urandom_range(0, 3) == 0) begin
                    add_burst(k, $urandom_range(1, 6), seq,
                              $urandom_range(0, 7) != 0);
                    seq += 8;
                end
            end
            step(N'($urandom), $urandom_range(0, 3) != 0, c == 300);
        end

        // drain
        for (int c = 0; c < 400 && (exp_q.size() > 0 || pend_total() > 0);
             c++) begin
            step('1, 1'b1, 1'b0);
        end
        repeat (4) step('0, 1'b1, 1'b0);
        check("drain_left", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
